// File: rtl/vreg_multiport_ram.sv
// Multi-read-port register RAM with byte-enabled writes and a hardware init/clear sweep.
// Sweeps write CLR_VAL to every entry. Reads are write-first and stay off while a sweep runs.
module vreg_multiport_ram #(
  parameter int              WIDTH   = 32,
  parameter int              ADDR_W  = 10,
  parameter int              N_RD    = 2,
  parameter int              RD_REG  = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  output logic                     wr_ready,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*WIDTH-1:0]    rd_data,
  output logic [N_RD-1:0]          rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = WIDTH / 8;
  // The terminal count sits in the extra MSB, so the last entry is written before the exit.
  localparam logic [ADDR_W:0] TERM = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr, ptr_nxt, ptr_inc;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              sweep;
  logic              wr_accept;
  logic [WIDTH-1:0]  rd_word [N_RD];

  assign sweep     = (state != IDLE);
  assign busy      = sweep;
  assign wr_ready  = ~sweep;
  assign wr_accept = wr_en & ~sweep;
  assign ptr_inc   = ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      INIT, CLEAR: begin
        if (ptr_inc == TERM) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt   = ptr_inc;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  // The array has no reset; its contents are defined only by the sweep.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[ptr[ADDR_W-1:0]] <= CLR_VAL;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  genvar p;
  generate
    for (p = 0; p < N_RD; p++) begin : g_port
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[p*ADDR_W +: ADDR_W];

      // A write to the same address in the same cycle is merged in, byte by byte.
      always_comb begin
        rd_word[p] = mem[addr];
        if (wr_accept && (wr_addr == addr)) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_word[p][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end

      if (RD_REG != 0) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rd_valid[p]               <= 1'b0;
            rd_data[p*WIDTH +: WIDTH] <= '0;
          end else begin
            rd_valid[p] <= rd_en[p] & ~sweep;
            if (rd_en[p] && !sweep) rd_data[p*WIDTH +: WIDTH] <= rd_word[p];
          end
        end
      end else begin : g_comb
        assign rd_valid[p]               = rd_en[p] & ~sweep;
        assign rd_data[p*WIDTH +: WIDTH] = sweep ? '0 : rd_word[p];
      end
    end
  endgenerate

endmodule

// File: tb/tb_vreg_multiport_ram.sv
// Scoreboard bench: a registered 2-port instance and a combinational 4-port instance share the write side.
// A word-level model predicts every read. A negedge monitor pops one expectation per rd_valid pulse.
module tb_vreg_multiport_ram;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [3:0]  rd_en2;
  logic [15:0] rd_addr2;
  logic        busy, busy2, wr_ready, wr_ready2;
  logic [63:0] rd_data;
  logic [127:0] rd_data2;
  logic [1:0]  rd_valid;
  logic [3:0]  rd_valid2;

  vreg_multiport_ram #(.WIDTH(32), .ADDR_W(4), .N_RD(2), .RD_REG(1), .CLR_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  vreg_multiport_ram #(.WIDTH(32), .ADDR_W(4), .N_RD(4), .RD_REG(0), .CLR_VAL(32'h0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          sweep_left = 0;
  logic [31:0] model [16];
  logic [31:0] exp1 [2][$];
  logic [31:0] exp2 [4][$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: check status, drive inputs, predict reads, advance the model.
  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic [1:0] ren,
                               input logic [3:0] ra0, input logic [3:0] ra1, input logic clr);
    logic        idle;
    logic [3:0]  ra;
    logic [31:0] e;
    idle = (sweep_left == 0);
    checkOutput("busy", 32'(busy), 32'(!idle));
    checkOutput("wr_ready", 32'(wr_ready), 32'(idle));
    checkOutput("busy comb", 32'(busy2), 32'(!idle));
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    wr_be    = be;
    rd_en    = ren;
    rd_addr  = {ra1, ra0};
    rd_en2   = {ren, ren};
    rd_addr2 = {ra1, ra0, ra1, ra0};
    clr_req  = clr;
    if (idle) begin
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          ra = (p == 0) ? ra0 : ra1;
          e  = model[ra];
          if (we && wa == ra) e = mergeBytes(e, wd, be);
          exp1[p].push_back(e);
          exp2[p].push_back(e);
          exp2[p+2].push_back(e);
        end
      end
      if (we) model[wa] = mergeBytes(model[wa], wd, be);
      if (clr) begin
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        sweep_left = 16;
      end
    end else begin
      sweep_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic randomCycle(input int clr_odds);
    logic [3:0] wa;
    logic [3:0] ra0, ra1;
    wa  = 4'($urandom);
    ra0 = ($urandom_range(3, 0) == 0) ? wa : 4'($urandom);
    ra1 = ($urandom_range(3, 0) == 0) ? wa : 4'($urandom);
    applyStimulus(1'($urandom), wa, $urandom, 4'($urandom), 2'($urandom), ra0, ra1,
                  (clr_odds > 0) && ($urandom_range(clr_odds - 1, 0) == 0));
  endtask

  // Reset is asserted between edges; outputs must drop before the next clock edge.
  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'h1);
    checkOutput("reset wr_ready", 32'(wr_ready), 32'h0);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("reset rd_data lo", rd_data[31:0], 32'h0);
    checkOutput("reset rd_data hi", rd_data[63:32], 32'h0);
    checkOutput("reset rd_valid comb", 32'(rd_valid2), 32'h0);
    wr_en = 1'b0; rd_en = '0; rd_en2 = '0; clr_req = 1'b0;
    for (int p = 0; p < 2; p++) exp1[p].delete();
    for (int p = 0; p < 4; p++) exp2[p].delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_left = 16;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (rd_valid[p]) begin
          if (exp1[p].size() == 0) checkOutput($sformatf("reg port%0d spurious valid", p), 32'h1, 32'h0);
          else checkOutput($sformatf("reg port%0d data", p), rd_data[p*32 +: 32], exp1[p].pop_front());
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (rd_valid2[p]) begin
          if (exp2[p].size() == 0) checkOutput($sformatf("comb port%0d spurious valid", p), 32'h1, 32'h0);
          else checkOutput($sformatf("comb port%0d data", p), rd_data2[p*32 +: 32], exp2[p].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = '0; rd_addr = '0; rd_en2 = '0; rd_addr2 = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    #2;
    pulseReset();

    // INIT sweep with random traffic: writes dropped, reads ignored.
    for (int i = 0; i < 16; i++) randomCycle(4);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 2'b11, 4'(2*i), 4'(2*i+1), 1'b0);

    // Byte-enable merge, then simultaneous write/read on both ports, then wr_be=0.
    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 2'b00, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'd5, 32'h0000AA00, 4'b0010, 2'b00, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 2'b01, 4'd5, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd3, 32'h12345678, 4'hF, 2'b11, 4'd3, 4'd3, 1'b0);
    applyStimulus(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 2'b11, 4'd5, 4'd3, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd5, 4'd5, 1'b0);

    // Clear with a same-cycle write; traffic and clr_req during the sweep are dropped.
    applyStimulus(1'b1, 4'd7, 32'h00000001, 4'hF, 2'b00, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'd9, 32'hCAFEF00D, 4'hF, 2'b00, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 4'd7, 32'hBAD0BAD0, 4'hF, 2'b11, 4'd7, 4'd9, 1'($urandom));
    applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd7, 4'd9, 1'b0);

    for (int i = 0; i < 200; i++) randomCycle(40);
    while (sweep_left > 0) idleCycles(1);

    // Reset at sweep cycle 9, then a full INIT runs again.
    applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0, 1'b1);
    idleCycles(9);
    pulseReset();
    for (int i = 0; i < 16; i++) randomCycle(0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 2'b11, 4'(15-2*i), 4'(14-2*i), 1'b0);
    for (int i = 0; i < 100; i++) randomCycle(0);
    idleCycles(3);

    for (int p = 0; p < 2; p++) checkOutput($sformatf("reg port%0d pending reads", p), 32'(exp1[p].size()), 32'h0);
    for (int p = 0; p < 4; p++) checkOutput($sformatf("comb port%0d pending reads", p), 32'(exp2[p].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
